// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO read engine.
// FIFO_RD_TIMEOUT_EN (see fifo_reader) does not change anything in this package.
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam int OBUF_DEPTH  = 3;
    localparam int ISSUE_LIMIT = OBUF_DEPTH - 1;

    function automatic logic [1:0] obuf_ptr_inc(input logic [1:0] p);
        return (p == 2'(OBUF_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/fifo_reader_if.sv
// FIFO read port and downstream valid/ready stream, grouped for fifo_reader.
// master = the reader engine, slave = FIFO plus downstream consumer.
interface fifo_reader_if #(
    parameter int WIDTH = 8
);
    logic             fifo_rd_n;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_dout;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;

    modport master (
        output fifo_rd_n,
        input  fifo_empty,
        input  fifo_dout,
        output m_valid,
        output m_data,
        input  m_ready
    );

    modport slave (
        input  fifo_rd_n,
        output fifo_empty,
        output fifo_dout,
        input  m_valid,
        input  m_data,
        output m_ready
    );
endinterface

// File: rtl/fifo_rd_obuf.sv
// Three-entry in-order output buffer between the FIFO read data and the stream.
// Overflow is prevented upstream by the issue limit, so push is not gated on full.
module fifo_rd_obuf
    import fifo_rd_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [1:0]       o_count,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);
    logic [WIDTH-1:0] r_mem [OBUF_DEPTH];
    logic [1:0]       r_rd_ptr;
    logic [1:0]       r_wr_ptr;
    logic [1:0]       r_count;
    logic             w_pop;

    assign w_pop   = i_pop && (r_count != 2'd0);
    assign o_count = r_count;
    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= obuf_ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= obuf_ptr_inc(r_rd_ptr);
            end
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

endmodule

// File: rtl/fifo_reader.sv
// Pops `count` words from a synchronous FIFO and streams them out on valid/ready.
// Optional macro FIFO_RD_TIMEOUT_EN aborts a command after TIMEOUT_CYCLES empty cycles.
module fifo_reader
    import fifo_rd_pkg::*;
#(
    parameter int          WIDTH          = 8,
    parameter int          CNT_W          = 16,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] words_read,
    fifo_reader_if.master    bus
);
    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_remaining;
    logic [CNT_W-1:0] r_words_read;
    logic             r_in_flight;
    logic [1:0]       w_buf_count;
    logic             w_issue;
    logic             w_start_acc;
    logic             w_pop;
    logic             w_to_hit;

    assign w_start_acc = (r_state == IDLE) && start;
    assign w_pop       = bus.m_valid && bus.m_ready;

    // Occupancy counts the word still in flight so a stalled stream can never overflow the buffer.
    assign w_issue = (r_state == RUN) && (r_remaining != '0) && !bus.fifo_empty
                     && (({1'b0, w_buf_count} + {2'b00, r_in_flight}) <= 3'(ISSUE_LIMIT))
                     && !reset;
    assign bus.fifo_rd_n = !w_issue;
    assign words_read    = r_words_read;

    fifo_rd_obuf #(
        .WIDTH(WIDTH)
    ) u_obuf (
        .clk    (clk),
        .reset  (reset),
        .i_push (r_in_flight),
        .i_din  (bus.fifo_dout),
        .i_pop  (bus.m_ready),
        .o_count(w_buf_count),
        .o_valid(bus.m_valid),
        .o_data (bus.m_data)
    );

`ifdef FIFO_RD_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] r_to_cnt;
    logic            r_timeout;

    assign w_to_hit = (r_state == RUN) && (r_remaining != '0) && bus.fifo_empty
                      && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign timeout  = r_timeout;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (w_start_acc || w_to_hit || !bus.fifo_empty) begin
                r_to_cnt <= '0;
            end else if ((r_state == RUN) && (r_remaining != '0)) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (w_start_acc) begin
                r_timeout <= 1'b0;
            end else if (w_to_hit) begin
                r_timeout <= 1'b1;
            end
        end
    end
`else
    logic [31:0] w_unused_timeout_cycles;

    assign w_unused_timeout_cycles = TIMEOUT_CYCLES;
    assign w_to_hit                = 1'b0;
    assign timeout                 = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_remaining  <= '0;
            r_words_read <= '0;
            r_in_flight  <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_in_flight <= w_issue;
            if (w_start_acc) begin
                r_remaining <= count;
            end else if (w_to_hit) begin
                r_remaining <= '0;
            end else if (w_issue) begin
                r_remaining <= r_remaining - CNT_W'(1);
            end
            if (w_start_acc) begin
                r_words_read <= '0;
            end else if (w_pop && (r_words_read != '1)) begin
                r_words_read <= r_words_read + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = (r_state != IDLE);
        done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = (count != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (w_to_hit || (r_remaining == '0)) begin
                    w_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!r_in_flight && (w_buf_count == 2'd0)) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader: behavioural FIFO, stream sink and hand-computed expectations.
// Build with FIFO_RD_TIMEOUT_EN defined to exercise the abort path.
module tb_fifo_reader;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] count = '0;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [15:0] words_read;

    fifo_reader_if #(.WIDTH(8)) bus ();

    fifo_reader #(
        .WIDTH         (8),
        .CNT_W         (16),
        .TIMEOUT_CYCLES(10)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout),
        .words_read(words_read),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // FIFO model: read accepted at the edge, data valid the following cycle
    logic [7:0] fmem [256];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic       flush = 1'b0;
    int         cyc = 0;
    int         issue_cnt = 0;
    int         last_issue = -1;

    assign bus.fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (flush) begin
            rd_ptr <= wr_ptr;
        end else if (!bus.fifo_rd_n && !bus.fifo_empty) begin
            bus.fifo_dout <= fmem[rd_ptr[7:0]];
            rd_ptr        <= rd_ptr + 1;
            issue_cnt     <= issue_cnt + 1;
            last_issue    <= cyc;
        end
    end

    // Stream sink and done monitor, sampled mid-cycle
    logic [7:0] rx_mem [256];
    int         rx_n = 0;
    int         last_pop = 0;
    int         done_cnt = 0;
    int         done_cyc = 0;

    always @(negedge clk) begin
        if (bus.m_valid && bus.m_ready) begin
            rx_mem[rx_n[7:0]] <= bus.m_data;
            rx_n              <= rx_n + 1;
            last_pop          <= cyc;
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        fmem[wr_ptr[7:0]] = d;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic cmd(input logic [15:0] c, output int t0);
        @(posedge clk); #1;
        start = 1'b1;
        count = c;
        t0    = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int base, input int max_cyc, input string tag);
        int n = 0;
        while (done_cnt == base && n < max_cyc) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, done_cnt - base, 1);
    endtask

    task automatic check_rx(input int base, input int n, input logic [7:0] first, input string tag);
        logic [7:0] idx;
        for (int i = 0; i < n; i++) begin
            idx = 8'(base + i);
            check(tag, rx_mem[idx], first + 8'(i));
        end
    endtask

    initial begin
        int t0, ib, rb, db, pc, n;

        bus.m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_timeout", timeout, 0);
        check("rst_words", words_read, 0);
        check("rst_mvalid", bus.m_valid, 0);
        check("rst_rd_n", bus.fifo_rd_n, 1);
        @(posedge clk); #1;
        reset = 1'b0;

        // Basic 16-word read at full throughput
        for (int i = 0; i < 16; i++) push(8'(i));
        bus.m_ready = 1'b1;
        ib = issue_cnt; rb = rx_n; db = done_cnt;
        cmd(16, t0);
        wait_done(db, 100, "basic_done");
        check("basic_issues", issue_cnt - ib, 16);
        check("basic_last_issue", last_issue - t0, 16);
        check("basic_rx_n", rx_n - rb, 16);
        check_rx(rb, 16, 8'h00, "basic_data");
        check("basic_done_lat", ((done_cyc - last_issue) >= 2) && ((done_cyc - last_issue) <= 5), 1);
        check("basic_words", words_read, 16);
        check("basic_timeout", timeout, 0);
        check("basic_idle", busy, 0);

        // Backpressure: only three reads may be outstanding
        for (int i = 0; i < 8; i++) push(8'hA0 + 8'(i));
        bus.m_ready = 1'b0;
        ib = issue_cnt; rb = rx_n; db = done_cnt;
        cmd(8, t0);
        repeat (20) @(posedge clk);
        #1;
        check("bp_issues", issue_cnt - ib, 3);
        check("bp_rd_n", bus.fifo_rd_n, 1);
        check("bp_mvalid", bus.m_valid, 1);
        check("bp_head", bus.m_data, 8'hA0);
        bus.m_ready = 1'b1;
        wait_done(db, 100, "bp_done");
        check("bp_rx_n", rx_n - rb, 8);
        check_rx(rb, 8, 8'hA0, "bp_data");
        check("bp_words", words_read, 8);

        // Empty stall: each read follows its write immediately
        ib = issue_cnt; rb = rx_n; db = done_cnt;
        cmd(4, t0);
        for (int i = 0; i < 4; i++) begin
            repeat (4) @(posedge clk);
            #1;
            check("stall_idle_rd_n", bus.fifo_rd_n, 1);
            push(8'h50 + 8'(i));
            pc = cyc;
            @(posedge clk); #1;
            check("stall_issue_cyc", last_issue, pc);
        end
        wait_done(db, 50, "stall_done");
        check("stall_rx_n", rx_n - rb, 4);
        check_rx(rb, 4, 8'h50, "stall_data");
        check("stall_words", words_read, 4);
        check("stall_timeout", timeout, 0);

        // Command larger than the FIFO contents
        push(8'h70); push(8'h71);
        ib = issue_cnt; rb = rx_n; db = done_cnt;
        cmd(5, t0);
`ifdef FIFO_RD_TIMEOUT_EN
        wait_done(db, 60, "to_done");
        check("to_timeout", timeout, 1);
        check("to_words", words_read, 2);
        check("to_lat", ((done_cyc - last_pop) >= 10) && ((done_cyc - last_pop) <= 13), 1);
        check_rx(rb, 2, 8'h70, "to_data");
        @(posedge clk); #1;
        check("to_hold", timeout, 1);
`else
        repeat (30) @(posedge clk);
        #1;
        check("nto_no_done", done_cnt - db, 0);
        check("nto_busy", busy, 1);
        check("nto_words", words_read, 2);
        check("nto_timeout", timeout, 0);
        push(8'h72); push(8'h73); push(8'h74);
        wait_done(db, 50, "nto_done");
        check("nto_words_end", words_read, 5);
        check_rx(rb, 5, 8'h70, "nto_data");
`endif

        // Zero count completes without touching the FIFO
        ib = issue_cnt; db = done_cnt;
        cmd(0, t0);
        check("zero_done", done, 1);
        @(posedge clk); #1;
        check("zero_done_pulse", done, 0);
        check("zero_busy", busy, 0);
        check("zero_issues", issue_cnt - ib, 0);
        check("zero_done_cnt", done_cnt - db, 1);

        // Start while busy is ignored
        for (int i = 0; i < 6; i++) push(8'hC0 + 8'(i));
        ib = issue_cnt; rb = rx_n; db = done_cnt;
        cmd(6, t0);
        check("ign_busy", busy, 1);
        cmd(3, t0);
        wait_done(db, 50, "ign_done");
        repeat (8) @(posedge clk);
        #1;
        check("ign_single_done", done_cnt - db, 1);
        check("ign_issues", issue_cnt - ib, 6);
        check("ign_rx_n", rx_n - rb, 6);
        check_rx(rb, 6, 8'hC0, "ign_data");
        check("ign_words", words_read, 6);
        check("ign_idle", busy, 0);

        // Reset in the middle of a command
        for (int i = 0; i < 10; i++) push(8'hE0 + 8'(i));
        rb = rx_n; db = done_cnt;
        cmd(10, t0);
        n = 0;
        while ((rx_n - rb) < 3 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("rst_mid_reached", (rx_n - rb) >= 3, 1);
        reset = 1'b1;
        bus.m_ready = 1'b0;
        #1;
        check("rst_mid_rd_n", bus.fifo_rd_n, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_mid_mvalid", bus.m_valid, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_words", words_read, 0);
        ib = issue_cnt;
        repeat (10) @(posedge clk);
        #1;
        check("rst_mid_no_done", done_cnt - db, 0);
        check("rst_mid_no_reads", issue_cnt - ib, 0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
